// File: rtl/jx2_mmio_bridge.sv
// jx2_mmio_bridge
//   Request/response bridge from the core memory port to the MMIO bus that
//   serves the GPIO/UART/timer block. Each core access becomes exactly one
//   MMIO transaction with its own rising OE/WR edge. After every access the
//   bridge forces an idle gap so the UART FIFO push/pop logic never misses
//   an edge.
//
//   Optional feature macro: JX2_MMIO_TIMEOUT_EN
//     When it is defined, a stalled device is aborted after 2^TMO_BITS-1 WAIT
//     cycles. The core then sees FAULT and memOutData = 32'hFFFFFFFF.
//     When it is undefined, WAIT lasts until the device answers.
//
// Ports
//   clock        system clock, all state on the rising edge
//   reset        synchronous active-low reset
//   memAddr      core request address
//   memInData    core write data
//   memOpm       core op: [3]=OE (read), [4]=WR (write), 0 = idle
//   memOutData   read data returned to the core (registered)
//   memOK        core status: 00 READY, 01 OK, 10 HOLD, 11 FAULT (registered)
//   mmioAddr     device address (registered)
//   mmioOutData  device write data (registered)
//   mmioOpm      device op (registered)
//   mmioInData   device read data
//   mmioOK       device status, same encoding as memOK
module jx2_mmio_bridge #(
  parameter logic [15:0] ADDR_HI  = 16'hF000,
  parameter int          TMO_BITS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] memAddr,
  input  logic [31:0] memInData,
  input  logic [4:0]  memOpm,
  output logic [31:0] memOutData,
  output logic [1:0]  memOK,
  output logic [31:0] mmioAddr,
  output logic [31:0] mmioOutData,
  output logic [4:0]  mmioOpm,
  input  logic [31:0] mmioInData,
  input  logic [1:0]  mmioOK
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  localparam logic [1:0] OK_READY = 2'b00;
  localparam logic [1:0] OK_OK    = 2'b01;
  localparam logic [1:0] OK_HOLD  = 2'b10;
  localparam logic [1:0] OK_FAULT = 2'b11;

  logic [2:0]  state_r;
  logic [31:0] reqAddr_r;
  logic [31:0] reqData_r;
  logic [4:0]  reqOpm_r;
  logic        fault_r;

  logic reqActive_s;
  logic inWindow_s;
  logic tmoExpire_s;

  // Only OE/WR decide whether the core is asking for an access.
  assign reqActive_s = (memOpm[4:3] != 2'b00);
  assign inWindow_s  = (memAddr[31:16] == ADDR_HI);

`ifdef JX2_MMIO_TIMEOUT_EN
  localparam logic [TMO_BITS-1:0] TMO_MAX  = {TMO_BITS{1'b1}};
  localparam logic [TMO_BITS-1:0] TMO_LAST = TMO_MAX - {{(TMO_BITS-1){1'b0}}, 1'b1};

  logic [TMO_BITS-1:0] tmoCnt_r;

  // The timeout fires on the edge where the counter steps onto its maximum,
  // so the abort happens after exactly 2^TMO_BITS-1 WAIT cycles.
  assign tmoExpire_s = (tmoCnt_r == TMO_LAST);

  // WAIT-cycle counter: cleared in ISSUE, saturating increment in WAIT.
  always_ff @(posedge clock) begin
    if (!reset) begin
      tmoCnt_r <= {TMO_BITS{1'b0}};
    end else if (state_r == ST_ISSUE) begin
      tmoCnt_r <= {TMO_BITS{1'b0}};
    end else if ((state_r == ST_WAIT) && (tmoCnt_r != TMO_MAX)) begin
      tmoCnt_r <= tmoCnt_r + {{(TMO_BITS-1){1'b0}}, 1'b1};
    end else begin
      tmoCnt_r <= tmoCnt_r;
    end
  end
`else
  // Without the timeout, WAIT never expires. TMO_BITS only sizes the
  // counter of the timeout build.
  assign tmoExpire_s = (TMO_BITS < 0);
`endif

  // Bridge FSM. It drives every core-side and device-side output from registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      reqAddr_r   <= 32'd0;
      reqData_r   <= 32'd0;
      reqOpm_r    <= 5'd0;
      fault_r     <= 1'b0;
      mmioOpm     <= 5'd0;
      mmioAddr    <= 32'd0;
      mmioOutData <= 32'd0;
      memOK       <= OK_READY;
      memOutData  <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (reqActive_s && inWindow_s) begin
            // Latch the request now. Any later change by the core is ignored.
            reqAddr_r <= memAddr;
            reqData_r <= memInData;
            reqOpm_r  <= memOpm;
            fault_r   <= 1'b0;
            state_r   <= ST_ISSUE;
            memOK     <= OK_HOLD;
          end else if (reqActive_s) begin
            memOK <= OK_FAULT;
          end else begin
            memOK <= OK_READY;
          end
        end
        ST_ISSUE: begin
          mmioAddr    <= reqAddr_r;
          mmioOutData <= reqData_r;
          mmioOpm     <= reqOpm_r;
          state_r     <= ST_WAIT;
          memOK       <= OK_HOLD;
        end
        ST_WAIT: begin
          if (mmioOK == OK_OK) begin
            // Write-only accesses return zero, not whatever is on the bus.
            memOutData <= reqOpm_r[3] ? mmioInData : 32'd0;
            mmioOpm    <= 5'd0;
            state_r    <= ST_DONE;
            memOK      <= OK_OK;
          end else if (mmioOK == OK_FAULT) begin
            fault_r <= 1'b1;
            mmioOpm <= 5'd0;
            state_r <= ST_DONE;
            memOK   <= OK_FAULT;
          end else if (tmoExpire_s) begin
            fault_r    <= 1'b1;
            mmioOpm    <= 5'd0;
            memOutData <= 32'hFFFF_FFFF;
            state_r    <= ST_DONE;
            memOK      <= OK_FAULT;
          end else begin
            memOK <= OK_HOLD;
          end
        end
        ST_DONE: begin
          mmioOpm <= 5'd0;
          if (reqActive_s) begin
            memOK <= fault_r ? OK_FAULT : OK_OK;
          end else begin
            state_r <= ST_GAP;
            memOK   <= OK_READY;
          end
        end
        ST_GAP: begin
          // One forced idle cycle so the next access makes a fresh edge.
          mmioOpm <= 5'd0;
          fault_r <= 1'b0;
          memOK   <= OK_READY;
          state_r <= ST_IDLE;
        end
        default: begin
          mmioOpm <= 5'd0;
          memOK   <= OK_READY;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jx2_mmio_bridge.sv
// Self-checking bench for jx2_mmio_bridge. Transaction tasks build the
// expected per-cycle view of each access from the bridge's protocol rules.
// One compare process checks the DUT outputs against that view after every
// clock edge.
module tb_jx2_mmio_bridge;

  localparam logic [1:0] READY = 2'b00;
  localparam logic [1:0] OK    = 2'b01;
  localparam logic [1:0] HOLD  = 2'b10;
  localparam logic [1:0] FAULT = 2'b11;
  localparam logic [15:0] WIN  = 16'hF000;

  logic        clock;
  logic        reset;
  logic [31:0] memAddr;
  logic [31:0] memInData;
  logic [4:0]  memOpm;
  logic [31:0] memOutData;
  logic [1:0]  memOK;
  logic [31:0] mmioAddr;
  logic [31:0] mmioOutData;
  logic [4:0]  mmioOpm;
  logic [31:0] mmioInData;
  logic [1:0]  mmioOK;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  ok;
    logic [4:0]  opm;
    logic        cData;
    logic [31:0] data;
    logic        cBus;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t expQ[$];

  jx2_mmio_bridge #(.ADDR_HI(16'hF000), .TMO_BITS(4)) dut (
    .clock(clock), .reset(reset),
    .memAddr(memAddr), .memInData(memInData), .memOpm(memOpm),
    .memOutData(memOutData), .memOK(memOK),
    .mmioAddr(mmioAddr), .mmioOutData(mmioOutData), .mmioOpm(mmioOpm),
    .mmioInData(mmioInData), .mmioOK(mmioOK)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, want, $time);
    end
  endtask

  // Compare process: checks the queued expectation after every clock edge,
  // and checks that device op pulses are separated by at least two idle cycles.
  initial begin : compare
    exp_t e;
    int   zeroRun;
    bit   seenPulse;
    bit   prevBusy;
    zeroRun = 0;
    seenPulse = 1'b0;
    prevBusy = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        check("memOK", {30'd0, memOK}, {30'd0, e.ok});
        check("mmioOpm", {27'd0, mmioOpm}, {27'd0, e.opm});
        if (e.cData) check("memOutData", memOutData, e.data);
        if (e.cBus) begin
          check("mmioAddr", mmioAddr, e.addr);
          check("mmioOutData", mmioOutData, e.wdata);
        end
      end
      if (mmioOpm != 5'd0) begin
        if (!prevBusy && seenPulse) check("opmGap>=2", {31'd0, zeroRun >= 2}, 32'd1);
        seenPulse = 1'b1;
        prevBusy = 1'b1;
        zeroRun = 0;
      end else begin
        prevBusy = 1'b0;
        zeroRun++;
      end
    end
  end

  // Queue the expectation for the next edge, then step past that edge.
  task automatic cyc(input logic [1:0] eOk, input logic [4:0] eOpm,
                     input logic cData, input logic [31:0] eData,
                     input logic cBus, input logic [31:0] eAddr, input logic [31:0] eWdata);
    exp_t e;
    e.ok = eOk; e.opm = eOpm; e.cData = cData; e.data = eData;
    e.cBus = cBus; e.addr = eAddr; e.wdata = eWdata;
    expQ.push_back(e);
    @(posedge clock);
    #2;
  endtask

  // One complete core access. The device answers `resp` during WAIT cycle
  // `waitCycles`. The core holds its op for `hold` DONE cycles.
  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic [4:0] op,
                        input int waitCycles, input logic [1:0] resp,
                        input logic [31:0] rdata, input int hold);
    logic [31:0] expData;
    memAddr = a; memInData = d; memOpm = op; mmioOK = READY;
    if (a[31:16] != WIN) begin
      for (int i = 0; i < hold; i++) cyc(FAULT, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
      memOpm = 5'd0;
      cyc(READY, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
      return;
    end
    cyc(HOLD, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    // The core wanders during HOLD. The device must still see the latched request.
    memAddr = ~a; memInData = ~d;
    for (int i = 0; i < waitCycles; i++) cyc(HOLD, op, 1'b0, 32'd0, 1'b1, a, d);
    mmioOK = resp; mmioInData = rdata;
    expData = op[3] ? rdata : 32'd0;
    for (int i = 0; i < hold; i++) begin
      cyc(resp, 5'd0, resp == OK, expData, 1'b0, 32'd0, 32'd0);
      mmioOK = READY; mmioInData = 32'hDEAD_BEEF;
    end
    memOpm = 5'd0; memAddr = 32'd0; memInData = 32'd0;
    cyc(READY, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    cyc(READY, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin : stim
    reset = 1'b0; memAddr = 32'd0; memInData = 32'd0; memOpm = 5'd0;
    mmioInData = 32'd0; mmioOK = READY;
    // Reset state.
    cyc(READY, 5'd0, 1'b1, 32'd0, 1'b1, 32'd0, 32'd0);
    cyc(READY, 5'd0, 1'b1, 32'd0, 1'b1, 32'd0, 32'd0);
    reset = 1'b1;
    cyc(READY, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    // Op bits other than OE/WR do not start an access.
    memAddr = 32'hF000_E000; memOpm = 5'b00111;
    cyc(READY, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    memOpm = 5'd0;

    // Read; the device answers OK on the 2nd WAIT cycle.
    access(32'hF000_E000, 32'd0, 5'b01000, 2, OK, 32'h1234_5678, 2);
    check("readData", memOutData, 32'h1234_5678);
    // Write, then a second write at minimum turnaround.
    access(32'hF000_E014, 32'h0000_0041, 5'b10000, 2, OK, 32'hAAAA_5555, 1);
    check("writeData0", memOutData, 32'd0);
    access(32'hF000_E014, 32'h0000_0042, 5'b10000, 3, OK, 32'h5555_AAAA, 1);
    // Access outside the window.
    access(32'h0000_E000, 32'd0, 5'b01000, 0, FAULT, 32'd0, 3);
    // The device reports FAULT.
    access(32'hF000_E020, 32'd0, 5'b01000, 3, FAULT, 32'd0, 2);
    // OE and WR together, with other op bits, pass through as one access.
    access(32'hF000_E030, 32'h0000_0077, 5'b11101, 4, OK, 32'hCAFE_F00D, 1);
    check("rwData", memOutData, 32'hCAFE_F00D);

`ifdef JX2_MMIO_TIMEOUT_EN
    // The device never answers. The bridge aborts after 15 WAIT cycles.
    memAddr = 32'hF000_E040; memInData = 32'd0; memOpm = 5'b01000; mmioOK = READY;
    cyc(HOLD, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 15; i++) cyc(HOLD, 5'b01000, 1'b0, 32'd0, 1'b1, 32'hF000_E040, 32'd0);
    cyc(FAULT, 5'd0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd0);
    memOpm = 5'd0;
    cyc(READY, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    cyc(READY, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    check("tmoData", memOutData, 32'hFFFF_FFFF);
`else
    // Without the timeout, a slow device is simply waited for.
    access(32'hF000_E040, 32'd0, 5'b01000, 20, OK, 32'h0BAD_F00D, 1);
    check("slowData", memOutData, 32'h0BAD_F00D);
`endif

    // Reset during WAIT aborts the access; the next read still works.
    memAddr = 32'hF000_E000; memInData = 32'd0; memOpm = 5'b01000; mmioOK = READY;
    cyc(HOLD, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    cyc(HOLD, 5'b01000, 1'b0, 32'd0, 1'b1, 32'hF000_E000, 32'd0);
    reset = 1'b0;
    cyc(READY, 5'd0, 1'b1, 32'd0, 1'b1, 32'd0, 32'd0);
    reset = 1'b1; memOpm = 5'd0;
    cyc(READY, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    access(32'hF000_E000, 32'd0, 5'b01000, 2, OK, 32'h8765_4321, 1);
    check("postResetData", memOutData, 32'h8765_4321);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
